imem_loader: RTL

- Program loader that writes the instruction memory which the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Writes each word to consecutive instruction-memory word addresses starting at 0.
- Holds the processor core in reset while loading and releases it when the load completes.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Purpose: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory, holding the core in reset while loading.
// Latency: a word is written the cycle after its 4th byte is accepted; done pulses one cycle after the last write.
// Backpressure: byte_ready is high for every LOAD cycle except the final write cycle; no mid-load stalls, idle gaps beyond TIMEOUT abort to ERR.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDLE_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [23:0]       shift_buf;

    logic              xfer;
    logic              len_ok;
    logic              word_end;
    logic              last_word;
    logic              load_entry;

    assign xfer       = byte_valid && byte_ready;
    assign len_ok     = (load_len != '0) && (load_len <= (ADDR_W+1)'(DEPTH));
    assign word_end   = xfer && (byte_cnt == 2'd3);
    // The final word's 4th byte: byte_ready must drop in the cycle its write appears.
    assign last_word  = word_end && (word_cnt == (len_q - (ADDR_W+1)'(1)));
    assign load_entry = (state != S_LOAD) && (state_nxt == S_LOAD);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; after the last write word_cnt equals len_q, which ends the load.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = len_ok ? S_LOAD : S_ERR;
                end
            end
            S_LOAD: begin
                if (word_cnt == len_q) begin
                    state_nxt = S_DONE;
                end else if (!xfer && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (start && len_ok) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_ready <= (state_nxt == S_LOAD) && !last_word;
            core_rst_n <= (state_nxt == S_IDLE);
            busy       <= (state_nxt == S_LOAD);
            done       <= (state_nxt == S_DONE);
            err        <= (state_nxt == S_ERR);
        end
    end

    // Memory write port: strobe for one cycle per completed word, address/data held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_end;
            if (word_end) begin
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {byte_data, shift_buf};
            end
        end
    end

    // Byte/word/idle counters and the partial-word buffer; a new load starts from a clean slate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q     <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            shift_buf <= '0;
        end else if (load_entry) begin
            len_q     <= load_len;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            shift_buf <= '0;
        end else if (state == S_LOAD) begin
            if (xfer) begin
                idle_cnt <= '0;
                if (word_end) begin
                    byte_cnt <= '0;
                    word_cnt <= word_cnt + (ADDR_W+1)'(1);
                end else begin
                    shift_buf[{byte_cnt, 3'b000} +: 8] <= byte_data;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule
